dcache: RTL
===========

Name: dcache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Sits between the CPU memory stage (the initiator of loads and stores) and a slower backing data memory.
- Answers CPU accesses: hits complete in the same cycle; misses and all stores raise `stall` until the backing memory completes.
- Issues req/ack transactions downstream.

Parameters:
- SETS, 16, number of cache lines (power of two, ≥2). Each line holds one 32-bit word.
- IDXW, $clog2(SETS), index width. Tag width = 30 − IDXW.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_re  in  1  load request
- cpu_we  in  1  store request (wins over cpu_re if both set)
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data (low bits used for sb/sh)
- cpu_width  in  3  funct3 encoding: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu (stores use 000/001/010)
- cpu_rdata  out  32  load result, sign/zero extended
- stall  out  1  CPU must hold its request and pipeline while high
- mem_req  out  1  backing-memory request
- mem_we  out  1  1 = write, 0 = word read
- mem_addr  out  32  word-aligned address (cpu_addr with [1:0] = 00)
- mem_wdata  out  32  write data, lane-aligned
- mem_wstrb  out  4  byte enables for writes; 0000 on reads
- mem_ack  in  1  single-cycle completion pulse; mem_rdata valid in the same cycle
- mem_rdata  in  32  read word

Behaviour:
- Storage: valid[SETS], tag[SETS], data[SETS]. index = addr[IDXW+1:2]; tag = addr[31:IDXW+2]. hit = valid[index] & tag match.
- Reset (rst=0, asynchronous): all valid bits cleared, state = IDLE. Tag and data arrays are not reset.
  - Outputs during and after reset: mem_req=0, mem_we=0, mem_wstrb=0, stall=0, cpu_rdata=0 (until a request arrives).
  - Reset mid-transaction abandons it and drops mem_req immediately. A later mem_ack in IDLE is ignored.
- FSM states: IDLE, REFILL, WRITE.
- IDLE:
  - cpu_we: stall=1 combinationally; next state WRITE.
  - cpu_re & hit: cpu_rdata = extracted data, stall=0. Zero-cycle latency; state stays IDLE.
  - cpu_re & miss: stall=1; next state REFILL.
  - No request: stall=0.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr held.
  - Without mem_ack: stall=1.
  - In the mem_ack cycle: stall=0 and cpu_rdata is extracted from mem_rdata, so the CPU advances on that edge. On that edge the line is written (valid=1, tag, data) and the FSM returns to IDLE.
  - Miss latency = backing latency + 1 cycle.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr held; mem_wstrb/mem_wdata follow cpu_width and addr[1:0]:
    - sb: strobe 0001<<addr[1:0], byte replicated across lanes.
    - sh: strobe 0011<<addr[1:0] (addr[1] selects the half), half replicated.
    - sw: strobe 1111.
  - stall=1 until mem_ack. In the ack cycle stall=0; on that edge, if hit, the strobed bytes of data[index] are merged. On a miss the cache is left unchanged. Next state IDLE.
- Load extraction: byte/half selected by addr[1:0]; lb/lh sign-extend, lbu/lhu zero-extend, lw passthrough.
- Misaligned accesses (lh at addr[0]=1, lw at addr[1:0]≠0): the CPU never issues them; behaviour is unspecified and not checked.
- Requests arriving while a transaction is in flight are the same held request; they are not re-decoded.
- Only one outstanding backing transaction exists at any time. mem_req stays high until ack.

Decomposition:
- Package dcache_pkg:
  - state enum {IDLE, REFILL, WRITE}
  - width constants WIDTH_B=3'b000, WIDTH_H=3'b001, WIDTH_W=3'b010, WIDTH_BU=3'b100, WIDTH_HU=3'b101
- Sub-module dcache_align (combinational):
  - load extraction (word, addr[1:0], width → rdata)
  - store lane generation (wdata, addr[1:0], width → lane data, wstrb)
  - shared by the cache and by the bench's reference model.

Test Plan:
- Reset then lw 0x100 with backing mem[0x100]=0xDEADBEEF, ack after 3 cycles → stall high 3 cycles, rdata=0xDEADBEEF in ack cycle. Repeat lw 0x100 → stall=0 same cycle, no mem_req.
- Hit 0x100=0xDEADBEEF: lb 0x103 → 0xFFFFFFDE; lbu 0x103 → 0x000000DE; lh 0x100 → 0xFFFFBEEF; lhu 0x102 → 0x0000DEAD.
- sb 0x101 data 0x55 on cached line → mem_wstrb=0010, mem_wdata=0x55555555, stall until ack. Then lw 0x101-aligned (0x100) hits → 0xDEAD55EF.
- sw 0x200 (not cached) → backing write, then lw 0x200 misses (no allocate) and refills value written.
- Conflict: SETS=16, refill 0x100 then lw 0x140 (same index, different tag) → miss, refill replaces line. lw 0x100 misses again.
- Assert rst low during REFILL before ack → mem_req=0 immediately. A late mem_ack is ignored. Subsequent lw 0x100 misses (valid cleared).

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared definitions for the data cache.
//   cacheState : FSM states (IDLE, REFILL, WRITE)
//   WIDTH_*    : funct3 access-width encodings used on cpu_width
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WRITE
    } cacheState;

    localparam logic [2:0] WIDTH_B  = 3'b000;
    localparam logic [2:0] WIDTH_H  = 3'b001;
    localparam logic [2:0] WIDTH_W  = 3'b010;
    localparam logic [2:0] WIDTH_BU = 3'b100;
    localparam logic [2:0] WIDTH_HU = 3'b101;

endpackage

// File: rtl/dcache_align.sv
// Byte-lane alignment for the data cache (purely combinational).
//   word     in  32  word read from the cache line or backing memory
//   offset   in  2   byte offset within the word (addr[1:0])
//   width    in  3   funct3 access width
//   wdata    in  32  CPU store data (low bits used for sb/sh)
//   rdata    out 32  load result, sign/zero extended
//   laneData out 32  store data replicated onto every lane
//   wstrb    out 4   byte enables for the store
module dcache_align
    import dcache_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  width,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] laneData,
    output logic [3:0]  wstrb
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    assign byteSel = word[{offset, 3'b000} +: 8];
    assign halfSel = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        rdata = word;
        unique case (width)
            WIDTH_B:  rdata = {{24{byteSel[7]}}, byteSel};
            WIDTH_BU: rdata = {24'h0, byteSel};
            WIDTH_H:  rdata = {{16{halfSel[15]}}, halfSel};
            WIDTH_HU: rdata = {16'h0, halfSel};
            default:  rdata = word;
        endcase
    end

    always_comb begin
        laneData = wdata;
        wstrb    = 4'b1111;
        unique case (width)
            WIDTH_B: begin
                laneData = {4{wdata[7:0]}};
                wstrb    = 4'b0001 << offset;
            end
            WIDTH_H: begin
                laneData = {2{wdata[15:0]}};
                wstrb    = 4'b0011 << offset;
            end
            default: begin
                laneData = wdata;
                wstrb    = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache, one word per line.
//   clk, rst (async, active-low)
//   cpu_re/cpu_we/cpu_addr/cpu_wdata/cpu_width : CPU request (store wins over load)
//   cpu_rdata, stall                           : load result and pipeline hold
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb : backing-memory request
//   mem_ack/mem_rdata                          : single-cycle completion and read word
module dcache
    import dcache_pkg::*;
#(
    parameter int unsigned SETS = 16,
    parameter int unsigned IDXW = $clog2(SETS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_re,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  cpu_width,
    output logic [31:0] cpu_rdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned TAGW = 30 - IDXW;

    cacheState         stateQ;
    logic [31:0]       reqAddrQ;
    logic [31:0]       reqWdataQ;
    logic [2:0]        reqWidthQ;
    logic [SETS-1:0]   validQ;
    logic [TAGW-1:0]   tagArr  [SETS];
    logic [31:0]       dataArr [SETS];

    // In IDLE the live request is decoded; once in flight the latched copy is used.
    logic [31:0]       curAddr;
    logic [31:0]       curWdata;
    logic [2:0]        curWidth;
    logic [IDXW-1:0]   idx;
    logic [TAGW-1:0]   tag;
    logic              hit;
    logic [31:0]       srcWord;
    logic [31:0]       extData;
    logic [31:0]       laneData;
    logic [3:0]        laneStrb;
    logic [31:0]       mergedWord;

    assign curAddr  = (stateQ == IDLE) ? cpu_addr  : reqAddrQ;
    assign curWdata = (stateQ == IDLE) ? cpu_wdata : reqWdataQ;
    assign curWidth = (stateQ == IDLE) ? cpu_width : reqWidthQ;
    assign idx      = curAddr[IDXW+1:2];
    assign tag      = curAddr[31:IDXW+2];
    assign hit      = validQ[idx] && (tagArr[idx] == tag);
    assign srcWord  = (stateQ == REFILL) ? mem_rdata : dataArr[idx];

    dcache_align uAlign (
        .word     (srcWord),
        .offset   (curAddr[1:0]),
        .width    (curWidth),
        .wdata    (curWdata),
        .rdata    (extData),
        .laneData (laneData),
        .wstrb    (laneStrb)
    );

    always_comb begin
        mergedWord = dataArr[idx];
        for (int b = 0; b < 4; b++) begin
            if (laneStrb[b]) mergedWord[8*b +: 8] = laneData[8*b +: 8];
        end
    end

    always_comb begin
        stall     = 1'b0;
        cpu_rdata = 32'h0;
        unique case (stateQ)
            IDLE: begin
                // Gated by rst so stall stays low while reset is held.
                stall = rst && (cpu_we || (cpu_re && !hit));
                if (cpu_re && !cpu_we && hit) cpu_rdata = extData;
            end
            REFILL: begin
                stall = !mem_ack;
                if (mem_ack) cpu_rdata = extData;
            end
            WRITE: stall = !mem_ack;
            default: stall = 1'b0;
        endcase
    end

    assign mem_req   = (stateQ != IDLE);
    assign mem_we    = (stateQ == WRITE);
    assign mem_addr  = {curAddr[31:2], 2'b00};
    assign mem_wdata = laneData;
    assign mem_wstrb = (stateQ == WRITE) ? laneStrb : 4'b0000;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ    <= IDLE;
            validQ    <= '0;
            reqAddrQ  <= 32'h0;
            reqWdataQ <= 32'h0;
            reqWidthQ <= 3'b000;
        end else begin
            unique case (stateQ)
                IDLE: begin
                    if (cpu_we || (cpu_re && !hit)) begin
                        stateQ    <= cpu_we ? WRITE : REFILL;
                        reqAddrQ  <= cpu_addr;
                        reqWdataQ <= cpu_wdata;
                        reqWidthQ <= cpu_width;
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        validQ[idx] <= 1'b1;
                        stateQ      <= IDLE;
                    end
                end
                WRITE: begin
                    if (mem_ack) stateQ <= IDLE;
                end
                default: stateQ <= IDLE;
            endcase
        end
    end

    // Tag/data arrays carry no reset; validQ alone qualifies them.
    always_ff @(posedge clk) begin
        if (stateQ == REFILL && mem_ack) begin
            tagArr[idx]  <= tag;
            dataArr[idx] <= mem_rdata;
        end else if (stateQ == WRITE && mem_ack && hit) begin
            dataArr[idx] <= mergedWord;
        end
    end

endmodule
